// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock supervisor with ordered per-domain reset release
// Holds the PLL in reset, qualifies lock, then releases domain resets one stage at a time.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int NUM_STAGES          = 3,
  parameter int STAGE_GAP_CYCLES    = 64
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_lost_count,
  output logic [7:0]            retry_count,
  output logic [2:0]            state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                max2(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES));
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_s;
  logic                    pll_rst_d;
  logic [NUM_STAGES-1:0]   rst_out_d;
  logic                    ready_d;
  logic [7:0]              lost_d;
  logic [7:0]              retry_d;
  logic                    lose_lock;

  // locked is asynchronous to refclk; only the last flop's output is trusted
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    pll_rst_d = pll_rst;
    rst_out_d = rst_out;
    ready_d   = ready;
    lost_d    = lock_lost_count;
    retry_d   = retry_count;
    lose_lock = 1'b0;

    case (state_q)
      S_PLL_RESET: begin
        pll_rst_d = 1'b1;
        if (cnt_q == PLL_LAST) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end

      S_WAIT_LOCK: begin
        pll_rst_d = 1'b0;
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_PLL_RESET;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          if (retry_count != 8'hff) begin
            retry_d = retry_count + 8'd1;
          end
        end
      end

      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d      = S_RELEASE;
          cnt_d        = '0;
          idx_d        = '0;
          rst_out_d[0] = 1'b0;
        end
      end

      S_RELEASE: begin
        if (!locked_s) begin
          lose_lock = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            for (int k = 1; k < NUM_STAGES; k++) begin
              if (k == int'(idx_q) + 1) begin
                rst_out_d[k] = 1'b0;
              end
            end
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          lose_lock = 1'b1;
        end
      end

      default: begin
        // illegal encoding: back to the reset posture, counters untouched
        state_d   = S_PLL_RESET;
        cnt_d     = '0;
        idx_d     = '0;
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase

    // loss of lock wins over any stage release due on the same cycle
    if (lose_lock) begin
      state_d   = S_PLL_RESET;
      cnt_d     = '0;
      idx_d     = '0;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      ready_d   = 1'b0;
      if (lock_lost_count != 8'hff) begin
        lost_d = lock_lost_count + 8'd1;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q         <= S_PLL_RESET;
      cnt_q           <= '0;
      idx_q           <= '0;
      pll_rst         <= 1'b1;
      rst_out         <= '1;
      ready           <= 1'b0;
      lock_lost_count <= 8'd0;
      retry_count     <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      pll_rst         <= pll_rst_d;
      rst_out         <= rst_out_d;
      ready           <= ready_d;
      lock_lost_count <= lost_d;
      retry_count     <= retry_d;
    end
  end

  assign state = state_q;

endmodule
